// File: rtl/maze_map_loader.sv
// Copies one maze (8 row bytes + start/end point bytes) from a selected ROM into
// a register-held map image, tracking ROM read latency, then checks the points.
module maze_map_loader #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [1:0]  map_sel,
  output logic [1:0]  rom_sel,
  output logic        rom_en,
  output logic [3:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        busy,
  output logic        done,
  output logic        map_valid,
  output logic        err,
  output logic [63:0] map_bits,
  output logic [5:0]  start_pos,
  output logic [5:0]  end_pos
);

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned NADDR = 10;

  typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      rom_sel_q, rom_sel_d;
  logic            rom_en_q, rom_en_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            map_valid_q, map_valid_d;
  logic            err_q, err_d;
  logic [63:0]     map_bits_q, map_bits_d;
  logic [5:0]      start_pos_q, start_pos_d;
  logic [5:0]      end_pos_q, end_pos_d;
  logic [DW-1:0]   start_byte_q, start_byte_d;
  logic [DW-1:0]   end_byte_q, end_byte_d;
  logic [AW:0]     tag_q [LAT];
  logic [AW:0]     tag_d [LAT];

  logic            tag_vld;
  logic [AW-1:0]   tag_addr;
  logic            start_open, end_open, fail;

  assign tag_vld  = tag_q[LAT-1][AW];
  assign tag_addr = tag_q[LAT-1][AW-1:0];

  // Point cell (row r, col c) sits at bit 8r + (7-c) of the map image.
  assign start_open = map_bits_q[{start_byte_q[5:3], ~start_byte_q[2:0]}];
  assign end_open   = map_bits_q[{end_byte_q[5:3], ~end_byte_q[2:0]}];
  assign fail = (|start_byte_q[7:6]) | (|end_byte_q[7:6]) | ~start_open | ~end_open
              | (start_byte_q[5:0] == end_byte_q[5:0]);

  always_comb begin
    state_d      = state_q;
    rom_sel_d    = rom_sel_q;
    rom_en_d     = rom_en_q;
    rom_addr_d   = rom_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    map_valid_d  = map_valid_q;
    err_d        = err_q;
    map_bits_d   = map_bits_q;
    start_pos_d  = start_pos_q;
    end_pos_d    = end_pos_q;
    start_byte_d = start_byte_q;
    end_byte_d   = end_byte_q;

    // Tag pipeline mirrors the ROM latency so data is matched to its address.
    tag_d[0] = {rom_en_q, rom_addr_q};
    for (int unsigned i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    unique case (state_q)
      IDLE: begin
        if (load) begin
          rom_sel_d   = map_sel;
          map_valid_d = 1'b0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          rom_en_d    = 1'b1;
          rom_addr_d  = '0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (rom_en_q) begin
          if (rom_addr_q == AW'(NADDR - 1)) begin
            rom_en_d   = 1'b0;
            rom_addr_d = '0;
          end else begin
            rom_addr_d = AW'(rom_addr_q + AW'(1));
          end
        end
        if (tag_vld) begin
          if (!tag_addr[3]) begin
            map_bits_d[{tag_addr[2:0], 3'b000} +: DW] = rom_data;
          end else if (!tag_addr[0]) begin
            start_byte_d = rom_data;
          end else begin
            end_byte_d = rom_data;
            state_d    = CHECK;
          end
        end
      end
      CHECK: begin
        start_pos_d = start_byte_q[5:0];
        end_pos_d   = end_byte_q[5:0];
        busy_d      = 1'b0;
        done_d      = 1'b1;
        map_valid_d = ~fail;
        err_d       = fail;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rom_sel_q    <= '0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      map_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      map_bits_q   <= '0;
      start_pos_q  <= '0;
      end_pos_q    <= '0;
      start_byte_q <= '0;
      end_byte_q   <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rom_sel_q    <= rom_sel_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      map_valid_q  <= map_valid_d;
      err_q        <= err_d;
      map_bits_q   <= map_bits_d;
      start_pos_q  <= start_pos_d;
      end_pos_q    <= end_pos_d;
      start_byte_q <= start_byte_d;
      end_byte_q   <= end_byte_d;
      for (int unsigned i = 0; i < LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign rom_sel   = rom_sel_q;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign map_valid = map_valid_q;
  assign err       = err_q;
  assign map_bits  = map_bits_q;
  assign start_pos = start_pos_q;
  assign end_pos   = end_pos_q;

endmodule

// File: tb/tb_maze_map_loader.sv
// Bench for maze_map_loader: LAT=1 and LAT=3 instances against latency-modelled
// ROMs, directed loads plus randomized maps checked against a point-rule model.
module tb_maze_map_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load1 = 1'b0, load3 = 1'b0;
  logic [1:0] map_sel = 2'd0;

  logic [1:0] rom_sel1, rom_sel3;
  logic rom_en1, rom_en3;
  logic [3:0] rom_addr1, rom_addr3;
  logic [7:0] rom_data1, rom_data3;
  logic busy1, busy3, done1, done3, mv1, mv3, err1, err3;
  logic [63:0] bits1, bits3;
  logic [5:0] sp1, sp3, ep1, ep3;

  logic [7:0] mem [4][10];
  logic [4:0] h1 = '0;
  logic [4:0] h3 [3] = '{default: '0};

  int checks = 0, passes = 0, fails = 0;
  int cur = 1;

  always #5 clk = ~clk;

  maze_map_loader #(.LAT(1)) u1 (
    .clk(clk), .rst(rst), .load(load1), .map_sel(map_sel), .rom_sel(rom_sel1),
    .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_data1), .busy(busy1),
    .done(done1), .map_valid(mv1), .err(err1), .map_bits(bits1),
    .start_pos(sp1), .end_pos(ep1));

  maze_map_loader #(.LAT(3)) u3 (
    .clk(clk), .rst(rst), .load(load3), .map_sel(map_sel), .rom_sel(rom_sel3),
    .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(rom_data3), .busy(busy3),
    .done(done3), .map_valid(mv3), .err(err3), .map_bits(bits3),
    .start_pos(sp3), .end_pos(ep3));

  // ROMs: address presented in cycle t returns data in cycle t+LAT; junk otherwise.
  always @(posedge clk) begin
    h1    <= {rom_en1, rom_addr1};
    h3[0] <= {rom_en3, rom_addr3};
    h3[1] <= h3[0];
    h3[2] <= h3[1];
  end
  always_comb rom_data1 = h1[4]    ? mem[rom_sel1][h1[3:0]]    : 8'hA5;
  always_comb rom_data3 = h3[2][4] ? mem[rom_sel3][h3[2][3:0]] : 8'h5A;

  logic [1:0] o_sel; logic o_en; logic [3:0] o_addr;
  logic o_busy, o_done, o_mv, o_err; logic [63:0] o_bits; logic [5:0] o_sp, o_ep;
  always_comb begin
    o_sel = cur == 3 ? rom_sel3 : rom_sel1;   o_en   = cur == 3 ? rom_en3 : rom_en1;
    o_addr = cur == 3 ? rom_addr3 : rom_addr1; o_busy = cur == 3 ? busy3 : busy1;
    o_done = cur == 3 ? done3 : done1;         o_mv   = cur == 3 ? mv3 : mv1;
    o_err = cur == 3 ? err3 : err1;            o_bits = cur == 3 ? bits3 : bits1;
    o_sp = cur == 3 ? sp3 : sp1;               o_ep   = cur == 3 ? ep3 : ep1;
  end

  function automatic logic [127:0] all_outs();
    return 128'({o_sel, o_en, o_addr, o_busy, o_done, o_mv, o_err, o_bits, o_sp, o_ep});
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a point is legal if its byte is below 64, its cell bit is 1, and the points differ.
  function automatic bit cell_open(input int sel, input int b);
    int row = b / 8;
    int col = b % 8;
    return ((int'(mem[sel][row]) >> (7 - col)) & 1) == 1;
  endfunction

  function automatic bit exp_fail(input int sel);
    int sb = int'(mem[sel][8]);
    int eb = int'(mem[sel][9]);
    if (sb >= 64 || eb >= 64) return 1'b1;
    if (!cell_open(sel, sb) || !cell_open(sel, eb)) return 1'b1;
    return sb == eb;
  endfunction

  function automatic logic [63:0] exp_bits(input int sel);
    logic [63:0] v = '0;
    for (int r = 0; r < 8; r++) v = v | (64'(mem[sel][r]) << (8 * r));
    return v;
  endfunction

  task automatic set_nominal(input int sel, input logic [7:0] sb, input logic [7:0] eb);
    logic [7:0] rows [8] = '{8'h3F, 8'h61, 8'h4D, 8'hE5, 8'hB7, 8'h11, 8'hF7, 8'h8C};
    for (int r = 0; r < 8; r++) mem[sel][r] = rows[r];
    mem[sel][8] = sb;
    mem[sel][9] = eb;
  endtask

  task automatic set_load(input bit v);
    if (cur == 3) load3 = v; else load1 = v;
  endtask

  // Starts a load at the current negedge (cycle 0) and checks it cycle by cycle.
  task automatic do_load(input int lat, input logic [1:0] sel, input bit reload4,
                         input bit rst5, input string tag);
    int dc = -1;
    bit seq_ok = 1'b1, busy_ok = 1'b1, sel_ok = 1'b1;
    cur = lat;
    map_sel = sel;
    set_load(1'b1);
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        set_load(1'b0);
        chk({tag, ".err_cleared"}, 128'(o_err), 128'(0));
        chk({tag, ".mv_cleared"}, 128'(o_mv), 128'(0));
      end
      if (reload4 && c == 4) begin set_load(1'b1); map_sel = ~sel; end
      if (reload4 && c == 5) begin set_load(1'b0); map_sel = sel; end
      if (rst5 && c == 5) begin
        rst = 1'b1;
        #1;
        chk({tag, ".reset_outs"}, all_outs(), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (c <= 10) seq_ok &= (o_en === 1'b1) && (o_addr === 4'(c - 1));
      else         seq_ok &= (o_en === 1'b0) && (o_addr === 4'd0);
      sel_ok &= (o_sel === sel);
      if (o_done === 1'b1) begin
        dc = c;
        chk({tag, ".busy_done"}, 128'(o_busy), 128'(0));
      end else begin
        busy_ok &= (o_busy === (c <= 11 + lat));
      end
    end
    chk({tag, ".done_cycle"}, 128'(dc), 128'(12 + lat));
    chk({tag, ".addr_seq"}, 128'(seq_ok), 128'(1));
    chk({tag, ".busy_seq"}, 128'(busy_ok), 128'(1));
    chk({tag, ".rom_sel"}, 128'(sel_ok), 128'(1));
    chk({tag, ".map_bits"}, 128'(o_bits), 128'(exp_bits(sel)));
    chk({tag, ".start_pos"}, 128'(o_sp), 128'(mem[sel][8] & 8'h3F));
    chk({tag, ".end_pos"}, 128'(o_ep), 128'(mem[sel][9] & 8'h3F));
    chk({tag, ".err"}, 128'(o_err), 128'(exp_fail(sel)));
    chk({tag, ".map_valid"}, 128'(o_mv), 128'(!exp_fail(sel)));
    @(negedge clk);
    chk({tag, ".done_pulse"}, 128'(o_done), 128'(0));
  endtask

  initial begin
    int dq [$];
    bit mv_low_ok = 1'b1;
    int seen;
    for (int s = 0; s < 4; s++) set_nominal(s, 8'h38, 8'h07);

    repeat (3) @(negedge clk);
    cur = 1;
    chk("reset.u1", all_outs(), 128'(0));
    cur = 3;
    chk("reset.u3", all_outs(), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    do_load(1, 2'd0, 1'b0, 1'b0, "nominal");
    set_nominal(0, 8'h00, 8'h07);
    do_load(1, 2'd0, 1'b0, 1'b0, "closed_start");
    set_nominal(0, 8'h38, 8'h47);
    do_load(1, 2'd0, 1'b0, 1'b0, "reserved_bits");
    set_nominal(0, 8'h07, 8'h07);
    do_load(1, 2'd0, 1'b0, 1'b0, "same_points");
    set_nominal(0, 8'h38, 8'h07);
    do_load(1, 2'd0, 1'b0, 1'b0, "recover");
    do_load(1, 2'd0, 1'b1, 1'b0, "ignored_load");
    do_load(1, 2'd1, 1'b0, 1'b1, "mid_reset");
    do_load(1, 2'd1, 1'b0, 1'b0, "after_reset");
    do_load(3, 2'd2, 1'b0, 1'b0, "lat3_sel2");

    // Back-to-back: load held high for 30 cycles.
    cur = 1;
    map_sel = 2'd0;
    load1 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done1 === 1'b1) dq.push_back(c);
      if (c >= 15 && c <= 26) mv_low_ok &= (mv1 === 1'b0);
      if (c == 27) chk("b2b.mv_at_27", 128'(mv1), 128'(1));
    end
    load1 = 1'b0;
    chk("b2b.done_count", 128'(dq.size()), 128'(2));
    chk("b2b.done_first", 128'(dq.size() > 0 ? dq[0] : -1), 128'(13));
    chk("b2b.done_second", 128'(dq.size() > 1 ? dq[1] : -1), 128'(27));
    chk("b2b.mv_low", 128'(mv_low_ok), 128'(1));
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (done1 === 1'b1) seen = 1;
    end
    chk("b2b.drain", 128'(seen), 128'(1));
    @(negedge clk);

    // Randomized maps and points, random select and latency.
    for (int it = 0; it < 10; it++) begin
      int sel = int'($urandom_range(0, 3));
      int lat = $urandom_range(0, 1) == 1 ? 3 : 1;
      int mode = int'($urandom_range(0, 3));
      int sb = int'($urandom_range(0, 63));
      int eb = int'($urandom_range(0, 63));
      for (int r = 0; r < 8; r++) mem[sel][r] = 8'($urandom);
      if (mode == 0) begin
        sb = int'($urandom_range(0, 255));
        eb = int'($urandom_range(0, 255));
      end else if (mode != 3) begin
        mem[sel][sb / 8] = mem[sel][sb / 8] | 8'(1 << (7 - sb % 8));
        mem[sel][eb / 8] = mem[sel][eb / 8] | 8'(1 << (7 - eb % 8));
      end
      mem[sel][8] = 8'(sb);
      mem[sel][9] = 8'(eb);
      do_load(lat, 2'(sel), 1'b0, 1'b0, $sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
